// File: rtl/kp_gaussian_mac.sv
// kp_gaussian_mac
//   Applies a 3x3 Gaussian kernel [1 2 1; 2 4 2; 1 2 1]/16 to each 3-row
//   window from kp_kernel_control. The pipeline has three register stages.
//   Line and frame position flags travel through the pipe alongside the data.
//   Optional feature macro: KP_GAUSS_ROUND_EN. When defined, the output is
//   rounded half-up and saturated. When undefined, the output is truncated.
module kp_gaussian_mac #(
  parameter int unsigned LINE_LENGTH = 640,
  parameter int unsigned LINE_COUNT  = 480,
  parameter int unsigned DATA_WIDTH  = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [3*DATA_WIDTH-1:0]   i_r0_data,
  input  logic [3*DATA_WIDTH-1:0]   i_r1_data,
  input  logic [3*DATA_WIDTH-1:0]   i_r2_data,
  input  logic                      i_valid,
  output logic [DATA_WIDTH-1:0]     o_data,
  output logic                      o_valid,
  output logic                      o_sol,
  output logic                      o_eol,
  output logic                      o_sof,
  output logic                      o_eof
);

  localparam int unsigned W      = DATA_WIDTH;
  localparam int unsigned PIX_W  = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
  localparam int unsigned LINE_W = (LINE_COUNT  > 1) ? $clog2(LINE_COUNT)  : 1;
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(LINE_LENGTH - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(LINE_COUNT - 1);

  // Flag vector order: {sol, eol, sof, eof}
  logic [PIX_W-1:0]  pix;
  logic [LINE_W-1:0] line;
  logic [3:0]        in_flags;

  logic              s1_valid;
  logic [W+1:0]      s1_h0, s1_h1, s1_h2;
  logic [3:0]        s1_flags;

  logic              s2_valid;
  logic [W+3:0]      s2_v;
  logic [3:0]        s2_flags;

  logic [W-1:0]      s3_result;
  logic              s3_valid;
  logic [3:0]        s3_flags;

  // Horizontal weighting l + 2c + r of one packed row (left in the top bits).
  function automatic logic [W+1:0] hsum(input logic [3*W-1:0] row);
    return {2'b00, row[3*W-1:2*W]} + {1'b0, row[2*W-1:W], 1'b0} + {2'b00, row[W-1:0]};
  endfunction

  // Position counters advance once per accepted window.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pix  <= '0;
      line <= '0;
    end else if (i_valid) begin
      if (pix == PIX_LAST) begin
        pix  <= '0;
        line <= (line == LINE_LAST) ? '0 : line + 1'b1;
      end else begin
        pix <= pix + 1'b1;
      end
    end
  end

  // Build the position flags of the window being accepted this cycle.
  always_comb begin
    in_flags    = '0;
    in_flags[3] = (pix == '0);
    in_flags[2] = (pix == PIX_LAST);
    in_flags[1] = (pix == '0) && (line == '0);
    in_flags[0] = (pix == PIX_LAST) && (line == LINE_LAST);
  end

  // Stage 1: horizontal sums for each row.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_h0    <= '0;
      s1_h1    <= '0;
      s1_h2    <= '0;
      s1_flags <= '0;
    end else begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_h0    <= hsum(i_r0_data);
        s1_h1    <= hsum(i_r1_data);
        s1_h2    <= hsum(i_r2_data);
        s1_flags <= in_flags;
      end
    end
  end

  // Stage 2: vertical weighting h0 + 2*h1 + h2.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s2_valid <= 1'b0;
      s2_v     <= '0;
      s2_flags <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_v     <= {2'b00, s1_h0} + {1'b0, s1_h1, 1'b0} + {2'b00, s1_h2};
        s2_flags <= s1_flags;
      end
    end
  end

`ifdef KP_GAUSS_ROUND_EN
  logic [W:0] rnd_q;

  // Normalise by 16 with round-half-up, clamping to full scale.
  always_comb begin
    rnd_q     = (W+1)'(({1'b0, s2_v} + (W+5)'(8)) >> 4);
    s3_result = rnd_q[W] ? '1 : rnd_q[W-1:0];
  end
`else
  // Normalise by 16 with truncation.
  always_comb begin
    s3_result = W'(s2_v >> 4);
  end
`endif

  // Stage 3: output register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s3_valid <= 1'b0;
      o_data   <= '0;
      s3_flags <= '0;
    end else begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        o_data   <= s3_result;
        s3_flags <= s2_flags;
      end
    end
  end

  assign o_valid = s3_valid;
  assign o_sol   = s3_valid & s3_flags[3];
  assign o_eol   = s3_valid & s3_flags[2];
  assign o_sof   = s3_valid & s3_flags[1];
  assign o_eof   = s3_valid & s3_flags[0];

endmodule

// File: tb/tb_kp_gaussian_mac.sv
// Self-checking bench for kp_gaussian_mac.
// Short line and frame sizes keep the position-flag wrap cases brief.
module tb_kp_gaussian_mac;

  localparam int unsigned LL = 4;
  localparam int unsigned LC = 2;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid;
  logic [3*DW-1:0] r0, r1, r2;
  logic [DW-1:0] dout;
  logic          dvalid, sol, eol, sof, eof;

  always #5 clk = ~clk;

  kp_gaussian_mac #(.LINE_LENGTH(LL), .LINE_COUNT(LC), .DATA_WIDTH(DW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_r0_data(r0), .i_r1_data(r1), .i_r2_data(r2), .i_valid(valid),
    .o_data(dout), .o_valid(dvalid),
    .o_sol(sol), .o_eol(eol), .o_sof(sof), .o_eof(eof)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned acc      = 0;  // accepted windows since the last reset

  // Stimulus rows; one entry per clock cycle.
  logic          s_rst[$];
  logic          s_valid[$];
  logic [23:0]   s_r0[$], s_r1[$], s_r2[$];
  // Observed outputs, sampled 1 time unit after each edge. Flag order is {sol,eol,sof,eof}.
  logic          ob_valid[$];
  logic [7:0]    ob_data[$];
  logic [3:0]    ob_flags[$];
  // Reference expectations, aligned with the observed samples.
  logic          ex_valid[$];
  logic [7:0]    ex_data[$];
  logic [3:0]    ex_flags[$];

  // Kernel reference: weighted sum of the 3x3 window, then divide by 16.
  function automatic logic [7:0] gauss_ref(input logic [23:0] a, input logic [23:0] b,
                                           input logic [23:0] c);
    logic [23:0] rows[3];
    int unsigned sum, q, w;
    rows = '{a, b, c};
    sum = 0;
    for (int r = 0; r < 3; r++)
      for (int col = 0; col < 3; col++) begin
        w = ((r == 1) ? 2 : 1) * ((col == 1) ? 2 : 1);
        sum += w * int'(rows[r][(2-col)*8 +: 8]);
      end
`ifdef KP_GAUSS_ROUND_EN
    q = (sum + 8) / 16;
    if (q > 255) q = 255;
`else
    q = sum / 16;
`endif
    return q[7:0];
  endfunction

  task automatic clear_stim();
    s_rst.delete(); s_valid.delete(); s_r0.delete(); s_r1.delete(); s_r2.delete();
  endtask

  task automatic add(input logic rb, input logic vb, input logic [23:0] a,
                     input logic [23:0] b, input logic [23:0] c);
    s_rst.push_back(rb); s_valid.push_back(vb);
    s_r0.push_back(a); s_r1.push_back(b); s_r2.push_back(c);
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) add(1'b0, 1'b0, 24'h0, 24'h0, 24'h0);
  endtask

  // Build expectations from the model, drive the stimulus rows and capture outputs.
  // A window driven in row j is expected in sample j+2 unless a reset lands in rows j..j+2.
  task automatic run_stim();
    int n;
    int unsigned p, l;
    logic killed;
    n = s_valid.size();
    ex_valid.delete(); ex_data.delete(); ex_flags.delete();
    ob_valid.delete(); ob_data.delete(); ob_flags.delete();
    for (int k = 0; k < n + 2; k++) begin
      ex_valid.push_back(1'b0); ex_data.push_back(8'h0); ex_flags.push_back(4'h0);
    end
    for (int j = 0; j < n; j++) begin
      if (s_rst[j]) acc = 0;
      else if (s_valid[j]) begin
        killed = 1'b0;
        for (int r = j; r <= j + 2 && r < n; r++) if (s_rst[r]) killed = 1'b1;
        p = acc % LL;
        l = (acc / LL) % LC;
        acc++;
        if (!killed) begin
          ex_valid[j+2] = 1'b1;
          ex_data[j+2]  = gauss_ref(s_r0[j], s_r1[j], s_r2[j]);
          ex_flags[j+2] = {p == 0, p == LL - 1, p == 0 && l == 0, p == LL - 1 && l == LC - 1};
        end
      end
    end
    for (int k = 0; k < n + 2; k++) begin
      if (k < n) begin
        rst = s_rst[k]; valid = s_valid[k]; r0 = s_r0[k]; r1 = s_r1[k]; r2 = s_r2[k];
      end else begin
        rst = 1'b0; valid = 1'b0; r0 = '0; r1 = '0; r2 = '0;
      end
      @(posedge clk);
      #1;
      ob_valid.push_back(dvalid);
      ob_data.push_back(dout);
      ob_flags.push_back({sol, eol, sof, eof});
    end
    rst = 1'b0; valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0; r0 = '0; r1 = '0; r2 = '0;
    repeat (2) @(posedge clk);
    #1;
    acc = 0;
    n_checks++;
    if (dvalid !== 1'b0 || dout !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_out valid=%0b data=%0d expected valid=0 data=0", dvalid, dout);
    end
    n_checks++;
    if ({sol, eol, sof, eof} !== 4'h0) begin
      n_fail++;
      $display("FAIL reset_flags got %b expected 0000", {sol, eol, sof, eof});
    end
    rst = 1'b0;
  endtask

  task automatic test_uniform();
    clear_stim();
    add(1'b0, 1'b1, {3{8'd100}}, {3{8'd100}}, {3{8'd100}});
    add_idle(3);
    run_stim();
    n_checks++;
    if (ob_valid[1] !== 1'b0 || ob_valid[2] !== 1'b1 || ob_data[2] !== 8'd100) begin
      n_fail++;
      $display("FAIL uniform_latency v1=%0b v2=%0b d=%0d expected 0 1 100",
               ob_valid[1], ob_valid[2], ob_data[2]);
    end
    for (int k = 0; k < ob_valid.size(); k++) begin
      n_checks++;
      if (ob_valid[k] !== ex_valid[k]) begin
        n_fail++;
        $display("FAIL uniform_valid k=%0d got %0b expected %0b", k, ob_valid[k], ex_valid[k]);
      end
    end
  endtask

  task automatic test_impulse();
    logic [7:0] small_exp;
`ifdef KP_GAUSS_ROUND_EN
    small_exp = 8'd1;
`else
    small_exp = 8'd0;
`endif
    clear_stim();
    add(1'b0, 1'b1, 24'h0, {8'd0, 8'd16, 8'd0}, 24'h0);
    add(1'b0, 1'b1, 24'h0, {8'd0, 8'd2, 8'd0}, 24'h0);
    add_idle(3);
    run_stim();
    n_checks++;
    if (ob_valid[2] !== 1'b1 || ob_data[2] !== 8'd4) begin
      n_fail++;
      $display("FAIL impulse16 valid=%0b data=%0d expected 1 4", ob_valid[2], ob_data[2]);
    end
    n_checks++;
    if (ob_valid[3] !== 1'b1 || ob_data[3] !== small_exp) begin
      n_fail++;
      $display("FAIL impulse2 valid=%0b data=%0d expected 1 %0d", ob_valid[3], ob_data[3], small_exp);
    end
  endtask

  task automatic test_saturate();
    clear_stim();
    for (int i = 0; i < 10; i++) add(1'b0, 1'b1, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF);
    add_idle(3);
    run_stim();
    for (int k = 2; k < 12; k++) begin
      n_checks++;
      if (ob_valid[k] !== 1'b1 || ob_data[k] !== 8'd255) begin
        n_fail++;
        $display("FAIL saturate k=%0d valid=%0b data=%0d expected 1 255", k, ob_valid[k], ob_data[k]);
      end
    end
  endtask

  task automatic test_positions();
    clear_stim();
    add(1'b1, 1'b0, 24'h0, 24'h0, 24'h0);
    for (int i = 0; i < 9; i++) add(1'b0, 1'b1, $urandom, $urandom, $urandom);
    add_idle(3);
    run_stim();
    // Window m (0-based) is driven in row m+1 and sampled at index m+3.
    n_checks++;
    if (ob_flags[3] !== 4'b1010) begin
      n_fail++; $display("FAIL pos_first flags=%b expected 1010", ob_flags[3]);
    end
    n_checks++;
    if (ob_flags[6] !== 4'b0100) begin
      n_fail++; $display("FAIL pos_eol3 flags=%b expected 0100", ob_flags[6]);
    end
    n_checks++;
    if (ob_flags[7] !== 4'b1000) begin
      n_fail++; $display("FAIL pos_sol4 flags=%b expected 1000", ob_flags[7]);
    end
    n_checks++;
    if (ob_flags[10] !== 4'b0101) begin
      n_fail++; $display("FAIL pos_eof7 flags=%b expected 0101", ob_flags[10]);
    end
    n_checks++;
    if (ob_flags[11] !== 4'b1010 || ob_valid[11] !== 1'b1) begin
      n_fail++; $display("FAIL pos_next_sof flags=%b valid=%0b expected 1010 1", ob_flags[11], ob_valid[11]);
    end
    for (int k = 0; k < ob_valid.size(); k++) begin
      n_checks++;
      if (ob_valid[k] !== ex_valid[k] || ob_flags[k] !== ex_flags[k]) begin
        n_fail++;
        $display("FAIL pos_model k=%0d valid=%0b flags=%b expected %0b %b",
                 k, ob_valid[k], ob_flags[k], ex_valid[k], ex_flags[k]);
      end
    end
  endtask

  task automatic test_valid_pattern();
    logic [4:0] pat;
    pat = 5'b10110;
    clear_stim();
    for (int i = 4; i >= 0; i--) add(1'b0, pat[i], $urandom, $urandom, $urandom);
    add_idle(3);
    run_stim();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (ob_valid[i+2] !== pat[4-i]) begin
        n_fail++;
        $display("FAIL vpat i=%0d got %0b expected %0b", i, ob_valid[i+2], pat[4-i]);
      end
    end
    for (int k = 0; k < ob_valid.size(); k++) begin
      if (ex_valid[k]) begin
        n_checks++;
        if (ob_data[k] !== ex_data[k] || ob_flags[k] !== ex_flags[k]) begin
          n_fail++;
          $display("FAIL vpat_model k=%0d data=%0d flags=%b expected %0d %b",
                   k, ob_data[k], ob_flags[k], ex_data[k], ex_flags[k]);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    clear_stim();
    add(1'b1, 1'b0, 24'h0, 24'h0, 24'h0);
    for (int i = 0; i < 4; i++) add(1'b0, 1'b1, $urandom, $urandom, $urandom);
    add(1'b1, 1'b0, 24'h0, 24'h0, 24'h0);
    add(1'b0, 1'b1, $urandom, $urandom, $urandom);
    add_idle(3);
    run_stim();
    n_checks++;
    if (ob_valid[5] !== 1'b0 || ob_valid[6] !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_discard v5=%0b v6=%0b expected 0 0", ob_valid[5], ob_valid[6]);
    end
    n_checks++;
    if (ob_valid[8] !== 1'b1 || ob_flags[8] !== 4'b1010) begin
      n_fail++;
      $display("FAIL midreset_restart valid=%0b flags=%b expected 1 1010", ob_valid[8], ob_flags[8]);
    end
    for (int k = 0; k < ob_valid.size(); k++) begin
      n_checks++;
      if (ob_valid[k] !== ex_valid[k]) begin
        n_fail++;
        $display("FAIL midreset_model k=%0d valid=%0b expected %0b", k, ob_valid[k], ex_valid[k]);
      end
    end
  endtask

  task automatic test_random();
    clear_stim();
    for (int i = 0; i < 80; i++)
      add(($urandom_range(0, 24) == 0), ($urandom_range(0, 9) < 7), $urandom, $urandom, $urandom);
    add_idle(3);
    run_stim();
    for (int k = 0; k < ob_valid.size(); k++) begin
      n_checks++;
      if (ob_valid[k] !== ex_valid[k] ||
          (ex_valid[k] && (ob_data[k] !== ex_data[k] || ob_flags[k] !== ex_flags[k])) ||
          (!ex_valid[k] && ob_flags[k] !== 4'h0)) begin
        n_fail++;
        $display("FAIL random k=%0d valid=%0b data=%0d flags=%b expected %0b %0d %b",
                 k, ob_valid[k], ob_data[k], ob_flags[k], ex_valid[k], ex_data[k], ex_flags[k]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; r0 = '0; r1 = '0; r2 = '0;
    test_reset();
    test_uniform();
    test_impulse();
    test_saturate();
    test_positions();
    test_valid_pattern();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
